// File: rtl/demux_1to8_deser.sv
// Serial-to-parallel receiver. Bits arrive LSB first and are steered by a select counter
// into a shadow word. Each completed word is presented on Y with a valid/ready handshake.
module demux_1to8_deser #(
    parameter  int WIDTH = 8,
    localparam int SEL_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             D,
    input  logic             D_valid,
    output logic [WIDTH-1:0] Y,
    output logic             Y_valid,
    input  logic             Y_ready,
    output logic [SEL_W-1:0] Sel,
    output logic             busy,
    output logic             overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_y;
    logic             r_y_valid;
    logic [SEL_W-1:0] r_sel;
    logic             r_busy;
    logic             r_overrun;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_shadow_nxt;
    logic [WIDTH-1:0] w_y_nxt;
    logic             w_y_valid_nxt;
    logic [SEL_W-1:0] w_sel_nxt;
    logic             w_overrun_nxt;

    logic w_handshake;
    logic w_start_acc;
    logic w_capture;
    logic w_last;

    // In DONE a start only counts when it rides on the handshake; otherwise it is ignored.
    assign w_handshake = (r_state == DONE) && r_y_valid && Y_ready;
    assign w_start_acc = start && ((r_state != DONE) || w_handshake);
    assign w_capture   = (r_state == FILL) && !start && D_valid;
    assign w_last      = (r_sel == SEL_W'(WIDTH - 1));

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shadow  <= {WIDTH{1'b0}};
            r_y       <= {WIDTH{1'b0}};
            r_y_valid <= 1'b0;
            r_sel     <= {SEL_W{1'b0}};
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shadow  <= w_shadow_nxt;
            r_y       <= w_y_nxt;
            r_y_valid <= w_y_valid_nxt;
            r_sel     <= w_sel_nxt;
            r_busy    <= (w_state_nxt != IDLE);
            r_overrun <= w_overrun_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = FILL;
                else       w_state_nxt = IDLE;
            end
            FILL: begin
                if (w_capture && w_last) w_state_nxt = DONE;
                else                     w_state_nxt = FILL;
            end
            DONE: begin
                if (w_handshake) w_state_nxt = start ? FILL : IDLE;
                else             w_state_nxt = DONE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath next values: shadow fill, word output, select counter and overrun flag.
    always_comb begin
        w_shadow_nxt  = r_shadow;
        w_y_nxt       = r_y;
        w_y_valid_nxt = r_y_valid;
        w_sel_nxt     = r_sel;
        w_overrun_nxt = r_overrun;

        if (w_start_acc) begin
            w_shadow_nxt  = {WIDTH{1'b0}};
            w_sel_nxt     = {SEL_W{1'b0}};
            w_overrun_nxt = 1'b0;
        end else if (w_capture) begin
            if (w_last) begin
                w_y_nxt       = {D, r_shadow[WIDTH-2:0]};
                w_y_valid_nxt = 1'b1;
                w_sel_nxt     = {SEL_W{1'b0}};
            end else begin
                w_shadow_nxt[r_sel] = D;
                w_sel_nxt           = r_sel + SEL_W'(1);
            end
        end else if ((r_state == DONE) && D_valid) begin
            w_overrun_nxt = 1'b1;
        end else begin
            w_overrun_nxt = r_overrun;
        end

        if (w_handshake) begin
            w_y_valid_nxt = 1'b0;
        end else begin
            w_y_valid_nxt = w_y_valid_nxt;
        end
    end

    assign Y       = r_y;
    assign Y_valid = r_y_valid;
    assign Sel     = r_sel;
    assign busy    = r_busy;
    assign overrun = r_overrun;

endmodule
